// File: rtl/latch_write_sequencer.sv
// Sequencer that turns write/clear requests into registered, glitch-free gate,
// clear and data controls for a bank of level-sensitive D latches.
module latch_write_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             wr_clear,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_g,
  output logic             lat_clr,
  output logic             busy,
  output logic             done
);

  localparam int MAX_SO  = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
  localparam int MAX_CYC = (MAX_SO > HOLD_CYC) ? MAX_SO : HOLD_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, CLEAR} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            accept;
  logic            g_nx, clr_nx, busy_nx, done_nx;

  // Counter is loaded with N-1 so a state lasts exactly N cycles.
  function automatic logic [CW-1:0] load_cnt(input int n);
    return CW'(n - 1);
  endfunction

  assign wr_ready = (state == IDLE) && !clr;
  assign accept   = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_d   <= '0;
      lat_g   <= 1'b0;
      lat_clr <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      lat_g   <= g_nx;
      lat_clr <= clr_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      if (accept && !wr_clear) lat_d <= wr_data;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = wr_clear ? CLEAR : SETUP;
          cnt_nx   = wr_clear ? load_cnt(OPEN_CYC) : load_cnt(SETUP_CYC);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nx = OPEN;
          cnt_nx   = load_cnt(OPEN_CYC);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      OPEN: begin
        if (cnt == '0) begin
          state_nx = HOLD;
          cnt_nx   = load_cnt(HOLD_CYC);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      HOLD, CLEAR: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are derived from the next state and registered, so they never glitch.
  always_comb begin
    g_nx    = (state_nx == OPEN);
    clr_nx  = (state_nx == CLEAR);
    busy_nx = (state_nx != IDLE);
    done_nx = (state != IDLE) && (state_nx == IDLE);
  end

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Scoreboard bench for latch_write_sequencer: expected latch-bank contents and
// completion cycles are queued at request time and checked at each done pulse.
module tb_latch_write_sequencer;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } sb_t;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_clear = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, lat_g, lat_clr, busy, done;
  logic [7:0] lat_d;
  logic [7:0] bank;

  logic       sw_clr = 1'b1;
  logic       sw_valid = 1'b0;
  logic [7:0] sw_ready, sw_g, sw_lclr, sw_busy, sw_done;
  logic [7:0] sw_d [8];

  int  checks = 0;
  int  errors = 0;
  int  overlap = 0;
  bit  mon_en = 1'b0;
  sb_t exp_q[$];

  always #5 clk = ~clk;

  latch_write_sequencer #(.WIDTH(8), .SETUP_CYC(1), .OPEN_CYC(2), .HOLD_CYC(1)) dut (
    .clk(clk), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_clear(wr_clear), .wr_data(wr_data), .lat_d(lat_d), .lat_g(lat_g),
    .lat_clr(lat_clr), .busy(busy), .done(done)
  );

  for (genvar i = 0; i < 8; i++) begin : g_sw
    latch_write_sequencer #(
      .WIDTH(8),
      .SETUP_CYC((i % 2) != 0 ? 3 : 1),
      .OPEN_CYC(((i / 2) % 2) != 0 ? 3 : 1),
      .HOLD_CYC(((i / 4) % 2) != 0 ? 3 : 1)
    ) u_sw (
      .clk(clk), .clr(sw_clr), .wr_valid(sw_valid), .wr_ready(sw_ready[i]),
      .wr_clear(1'b0), .wr_data(8'h5A), .lat_d(sw_d[i]), .lat_g(sw_g[i]),
      .lat_clr(sw_lclr[i]), .busy(sw_busy[i]), .done(sw_done[i])
    );
  end

  // Behavioural model of the latch bank driven by the DUT controls.
  always @(lat_g or lat_clr or lat_d) begin
    if (lat_clr)    bank = 8'h00;
    else if (lat_g) bank = lat_d;
  end

  always @(negedge clk) begin
    if (mon_en)
      assert (!((lat_g && lat_clr) || ((sw_g & sw_lclr) != 8'h00))) else overlap++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    tick;
    tick;
    mon_en = 1'b1;
    checks++; if (lat_d !== 8'h00) begin errors++; $display("FAIL rst_lat_d got %h want 00", lat_d); end
    checks++; if (lat_g !== 1'b0) begin errors++; $display("FAIL rst_lat_g got %b want 0", lat_g); end
    checks++; if (lat_clr !== 1'b1) begin errors++; $display("FAIL rst_lat_clr got %b want 1", lat_clr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got %b want 0", wr_ready); end
    clr = 1'b0;
    tick;
    checks++; if (lat_clr !== 1'b0) begin errors++; $display("FAIL rst_release_lat_clr got %b want 0", lat_clr); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", wr_ready); end
  endtask

  task automatic test_single_write;
    sb_t e;
    wr_valid = 1'b1; wr_clear = 1'b0; wr_data = 8'hA5;
    exp_q.push_back('{val: 8'hA5, cyc: 5});
    tick;
    wr_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      checks++; if (lat_d !== 8'hA5) begin errors++; $display("FAIL single_lat_d cyc %0d got %h want a5", k, lat_d); end
      checks++; if (lat_g !== (k == 2 || k == 3)) begin errors++; $display("FAIL single_lat_g cyc %0d got %b want %b", k, lat_g, (k == 2 || k == 3)); end
      checks++; if (busy !== (k <= 4)) begin errors++; $display("FAIL single_busy cyc %0d got %b want %b", k, busy, (k <= 4)); end
      checks++; if (done !== (k == 5)) begin errors++; $display("FAIL single_done cyc %0d got %b want %b", k, done, (k == 5)); end
      checks++; if (wr_ready !== (k >= 5)) begin errors++; $display("FAIL single_ready cyc %0d got %b want %b", k, wr_ready, (k >= 5)); end
      if (done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL single_sb unexpected done cyc %0d", k); end
        else begin
          e = exp_q.pop_front();
          if (bank !== e.val || k != e.cyc) begin errors++; $display("FAIL single_sb bank %h cyc %0d want %h cyc %0d", bank, k, e.val, e.cyc); end
        end
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    sb_t e;
    logic [7:0] want_d;
    wr_valid = 1'b1; wr_clear = 1'b0; wr_data = 8'hA5;
    exp_q.push_back('{val: 8'hA5, cyc: 5});
    tick;
    wr_data = 8'h3C;
    exp_q.push_back('{val: 8'h3C, cyc: 10});
    for (int k = 1; k <= 11; k++) begin
      if (k == 6) wr_valid = 1'b0;
      want_d = (k <= 5) ? 8'hA5 : 8'h3C;
      checks++; if (lat_d !== want_d) begin errors++; $display("FAIL b2b_lat_d cyc %0d got %h want %h", k, lat_d, want_d); end
      checks++; if (done !== (k == 5 || k == 10)) begin errors++; $display("FAIL b2b_done cyc %0d got %b want %b", k, done, (k == 5 || k == 10)); end
      checks++; if (busy !== ((k <= 4) || (k >= 6 && k <= 9))) begin errors++; $display("FAIL b2b_busy cyc %0d got %b", k, busy); end
      if (done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_sb unexpected done cyc %0d", k); end
        else begin
          e = exp_q.pop_front();
          if (bank !== e.val || k != e.cyc) begin errors++; $display("FAIL b2b_sb bank %h cyc %0d want %h cyc %0d", bank, k, e.val, e.cyc); end
        end
      end
      tick;
    end
  endtask

  task automatic test_clear;
    sb_t e;
    wr_valid = 1'b1; wr_clear = 1'b0; wr_data = 8'hA5;
    tick;
    wr_valid = 1'b0;
    for (int k = 1; k <= 5; k++) tick;
    wr_valid = 1'b1; wr_clear = 1'b1; wr_data = 8'hFF;
    exp_q.push_back('{val: 8'h00, cyc: 3});
    tick;
    wr_valid = 1'b0; wr_clear = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (lat_clr !== (k <= 2)) begin errors++; $display("FAIL clear_lat_clr cyc %0d got %b want %b", k, lat_clr, (k <= 2)); end
      checks++; if (lat_g !== 1'b0) begin errors++; $display("FAIL clear_lat_g cyc %0d got %b want 0", k, lat_g); end
      checks++; if (lat_d !== 8'hA5) begin errors++; $display("FAIL clear_lat_d cyc %0d got %h want a5", k, lat_d); end
      checks++; if (done !== (k == 3)) begin errors++; $display("FAIL clear_done cyc %0d got %b want %b", k, done, (k == 3)); end
      checks++; if (busy !== (k <= 2)) begin errors++; $display("FAIL clear_busy cyc %0d got %b want %b", k, busy, (k <= 2)); end
      if (done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL clear_sb unexpected done cyc %0d", k); end
        else begin
          e = exp_q.pop_front();
          if (bank !== e.val || k != e.cyc) begin errors++; $display("FAIL clear_sb bank %h cyc %0d want %h cyc %0d", bank, k, e.val, e.cyc); end
        end
      end
      tick;
    end
  endtask

  task automatic test_busy_stimulus;
    sb_t e;
    wr_valid = 1'b1; wr_clear = 1'b0; wr_data = 8'hA5;
    exp_q.push_back('{val: 8'hA5, cyc: 5});
    tick;
    wr_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 2) begin wr_data = 8'hFF; wr_clear = 1'b1; wr_valid = 1'b1; #1; end
      if (k == 3) begin wr_data = 8'h00; wr_clear = 1'b0; wr_valid = 1'b0; end
      checks++; if (lat_d !== 8'hA5) begin errors++; $display("FAIL busy_lat_d cyc %0d got %h want a5", k, lat_d); end
      checks++; if (wr_ready !== (k >= 5)) begin errors++; $display("FAIL busy_ready cyc %0d got %b want %b", k, wr_ready, (k >= 5)); end
      checks++; if (busy !== (k <= 4)) begin errors++; $display("FAIL busy_busy cyc %0d got %b want %b", k, busy, (k <= 4)); end
      checks++; if (lat_clr !== 1'b0) begin errors++; $display("FAIL busy_lat_clr cyc %0d got %b want 0", k, lat_clr); end
      if (done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL busy_sb unexpected done cyc %0d", k); end
        else begin
          e = exp_q.pop_front();
          if (bank !== e.val || k != e.cyc) begin errors++; $display("FAIL busy_sb bank %h cyc %0d want %h cyc %0d", bank, k, e.val, e.cyc); end
        end
      end
      tick;
    end
  endtask

  task automatic test_reset_mid_open;
    sb_t e;
    wr_valid = 1'b1; wr_clear = 1'b0; wr_data = 8'h5A;
    tick;
    wr_valid = 1'b0;
    tick;
    checks++; if (lat_g !== 1'b1) begin errors++; $display("FAIL mid_open_gate got %b want 1", lat_g); end
    clr = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_during_clr got %b want 0", wr_ready); end
    tick;
    checks++; if (lat_g !== 1'b0) begin errors++; $display("FAIL mid_lat_g got %b want 0", lat_g); end
    checks++; if (lat_clr !== 1'b1) begin errors++; $display("FAIL mid_lat_clr got %b want 1", lat_clr); end
    checks++; if (lat_d !== 8'h00) begin errors++; $display("FAIL mid_lat_d got %h want 00", lat_d); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done); end
    checks++; if (bank !== 8'h00) begin errors++; $display("FAIL mid_bank got %h want 00", bank); end
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done2 got %b want 0", done); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL mid_ready2 got %b want 0", wr_ready); end
    clr = 1'b0; wr_valid = 1'b1; wr_data = 8'h96;
    exp_q.push_back('{val: 8'h96, cyc: 5});
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_release got %b want 1", wr_ready); end
    tick;
    wr_valid = 1'b0;
    checks++; if (lat_clr !== 1'b0) begin errors++; $display("FAIL mid_release_lat_clr got %b want 0", lat_clr); end
    for (int k = 1; k <= 6; k++) begin
      checks++; if (lat_d !== 8'h96) begin errors++; $display("FAIL mid_rewrite_lat_d cyc %0d got %h want 96", k, lat_d); end
      checks++; if (done !== (k == 5)) begin errors++; $display("FAIL mid_rewrite_done cyc %0d got %b want %b", k, done, (k == 5)); end
      if (done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL mid_sb unexpected done cyc %0d", k); end
        else begin
          e = exp_q.pop_front();
          if (bank !== e.val || k != e.cyc) begin errors++; $display("FAIL mid_sb bank %h cyc %0d want %h cyc %0d", bank, k, e.val, e.cyc); end
        end
      end
      tick;
    end
  endtask

  task automatic test_param_sweep;
    int gcnt [8];
    int done_at [8];
    int s, o, h;
    for (int i = 0; i < 8; i++) begin gcnt[i] = 0; done_at[i] = 0; end
    sw_clr = 1'b1;
    tick;
    sw_clr = 1'b0; sw_valid = 1'b1;
    tick;
    sw_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (sw_g[i] === 1'b1) gcnt[i]++;
        if (sw_done[i] === 1'b1 && done_at[i] == 0) done_at[i] = k;
      end
      tick;
    end
    for (int i = 0; i < 8; i++) begin
      s = (i % 2) != 0 ? 3 : 1;
      o = ((i / 2) % 2) != 0 ? 3 : 1;
      h = ((i / 4) % 2) != 0 ? 3 : 1;
      checks++; if (gcnt[i] != o) begin errors++; $display("FAIL sweep_gate_len inst %0d got %0d want %0d", i, gcnt[i], o); end
      checks++; if (done_at[i] != s + o + h + 1) begin errors++; $display("FAIL sweep_done_cyc inst %0d got %0d want %0d", i, done_at[i], s + o + h + 1); end
      checks++; if (sw_d[i] !== 8'h5A) begin errors++; $display("FAIL sweep_lat_d inst %0d got %h want 5a", i, sw_d[i]); end
      checks++; if (sw_busy[i] !== 1'b0 || sw_ready[i] !== 1'b1) begin errors++; $display("FAIL sweep_idle inst %0d busy %b ready %b want 0 1", i, sw_busy[i], sw_ready[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_back_to_back;
    test_clear;
    test_busy_stimulus;
    test_reset_mid_open;
    test_param_sweep;
    checks++; if (overlap != 0) begin errors++; $display("FAIL gate_clr_overlap got %0d cycles want 0", overlap); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d entries want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
